ql_seq_divider: RTL and testbench



---
 rtl/ql_div_pkg.sv | 19 +
 rtl/ql_div_sub_step.sv | 21 ++
 rtl/ql_seq_divider.sv | 123 ++++++++++++
 tb/tb_ql_seq_divider.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ql_div_pkg.sv
// Shared types for the sequential restoring divider.
// State encoding and counter sizing helpers.
package ql_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } div_state_t;

    localparam int DEF_WIDTH = 16;

    function automatic int cnt_bits(input int w);
        return (w < 3) ? 1 : $clog2(w);
    endfunction

    localparam int CNT_W = cnt_bits(DEF_WIDTH);

endpackage

// File: rtl/ql_div_sub_step.sv
// One trial-subtract step of the restoring divider.
// Written as s + ~d + 1 so it lands on the carry chain.
module ql_div_sub_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   s,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] t,
    output logic             no_borrow
);

    logic [WIDTH:0] sum;

    // trial difference; a clear top bit means s >= d
    always_comb begin
        sum       = s + ~{1'b0, d} + (WIDTH+1)'(1);
        t         = sum[WIDTH-1:0];
        no_borrow = ~sum[WIDTH];
    end

endmodule

// File: rtl/ql_seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Divide-by-zero short-circuits straight to the finish state.
module ql_seq_divider
    import ql_div_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_bits(WIDTH);

    div_state_t       state;
    div_state_t       state_nx;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] d_r;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   s;
    logic [WIDTH-1:0] t;
    logic             no_borrow;
    logic [WIDTH-1:0] q_nx;
    logic [WIDTH-1:0] r_nx;
    logic             accept;
    logic             div_zero_in;

    assign s = {r_r, q_r[WIDTH-1]};

    ql_div_sub_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .s        (s),
        .d        (d_r),
        .t        (t),
        .no_borrow(no_borrow)
    );

    // next partial quotient / remainder from the trial subtract
    always_comb begin
        q_nx = {q_r[WIDTH-2:0], no_borrow};
        r_nx = no_borrow ? t : s[WIDTH-1:0];
    end

    // next-state and status outputs
    always_comb begin
        state_nx    = state;
        accept      = 1'b0;
        div_zero_in = (divisor == '0);
        busy        = 1'b0;
        done        = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = div_zero_in ? FIN : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    state_nx = FIN;
                end
            end
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // working registers and held results
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_r         <= '0;
            r_r         <= '0;
            d_r         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            if (div_zero_in) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                d_r <= divisor;
                q_r <= dividend;
                r_r <= '0;
                cnt <= CW'(WIDTH - 1);
            end
        end else if (state == RUN) begin
            q_r <= q_nx;
            r_r <= r_nx;
            cnt <= cnt - CW'(1);
            if (cnt == '0) begin
                quotient    <= q_nx;
                remainder   <= r_nx;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ql_seq_divider.sv
// Scoreboard bench for the sequential divider.
// Runs a 16-bit and an 8-bit instance side by side.
module tb_ql_seq_divider;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
        int          c0;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    logic        rst8;
    logic        start8;
    logic [7:0]  dvd8;
    logic [7:0]  dvs8;
    logic        busy8;
    logic        done8;
    logic [7:0]  quo8;
    logic [7:0]  rem8;
    logic        dbz8;

    exp_t        sb[$];
    exp_t        sb8[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [15:0] last_q = '0;
    logic [15:0] last_r = '0;
    logic        last_z = 1'b0;
    logic        prev_done8 = 1'b0;
    bit          fin8 = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    ql_seq_divider #(.WIDTH(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    ql_seq_divider #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .reset_n    (rst8),
        .start      (start8),
        .dividend   (dvd8),
        .divisor    (dvs8),
        .busy       (busy8),
        .done       (done8),
        .quotient   (quo8),
        .remainder  (rem8),
        .div_by_zero(dbz8)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t mdl(input logic [15:0] a, input logic [15:0] b,
                                 input int w, input int c0);
        exp_t e;
        e.a  = a;
        e.b  = b;
        e.c0 = c0;
        if (b == 0) begin
            e.q   = 16'((32'd1 << w) - 1);
            e.r   = a;
            e.z   = 1'b1;
            e.lat = 1;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.z   = 1'b0;
            e.lat = w + 1;
        end
        return e;
    endfunction

    function automatic logic [15:0] rnd(input int w, input bit is_div);
        int sel;
        logic [15:0] m;
        m   = 16'((32'd1 << w) - 1);
        sel = $urandom_range(0, 9);
        if (is_div && sel == 0) return '0;
        if (sel == 1) return 16'($urandom_range(1, 3));
        if (sel == 2) return m;
        return 16'($urandom) & m;
    endfunction

    // 16-bit monitor: pops the scoreboard when a result is due
    always @(negedge clk) begin
        exp_t e;
        int   k;
        if (reset_n) begin
            if (sb.size() != 0) begin
                e = sb[0];
                k = cyc - e.c0;
                chk("busy", busy, (!e.z && k >= 1 && k <= 16));
                if (k >= e.lat) begin
                    chk("done", done, 1);
                    chk("quotient", quotient, e.q);
                    chk("remainder", remainder, e.r);
                    chk("div_by_zero", div_by_zero, e.z);
                    if (!e.z) begin
                        chk("invariant", quotient * e.b + remainder, e.a);
                        chk("rem_lt_div", remainder < e.b, 1);
                    end
                    last_q = e.q;
                    last_r = e.r;
                    last_z = e.z;
                    void'(sb.pop_front());
                end else begin
                    chk("done_early", done, 0);
                    chk("hold_quotient", quotient, last_q);
                    chk("hold_remainder", remainder, last_r);
                end
            end else begin
                chk("idle_busy", busy, 0);
                chk("idle_done", done, 0);
                chk("idle_quotient", quotient, last_q);
                chk("idle_remainder", remainder, last_r);
                chk("idle_div_by_zero", div_by_zero, last_z);
            end
        end
    end

    // 8-bit monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst8) begin
            if (done8) begin
                chk("done8_pulse", prev_done8, 0);
                if (sb8.size() == 0) begin
                    chk("done8_unexpected", done8, 0);
                end else begin
                    e = sb8.pop_front();
                    chk("latency8", cyc - e.c0, e.lat);
                    chk("quotient8", quo8, e.q[7:0]);
                    chk("remainder8", rem8, e.r[7:0]);
                    chk("div_by_zero8", dbz8, e.z);
                    if (!e.z) begin
                        chk("invariant8", quo8 * e.b + rem8, e.a);
                    end
                end
            end
            prev_done8 = done8;
        end
    end

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(sb.size() == 0 && !busy && !done) && n < 200);
        if (n >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_idle: still busy after %0d cycles", n);
        end
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        wait_idle();
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back(mdl(a, b, 16, cyc));
        @(negedge clk);
        #1;
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
    endtask

    // 8-bit random driver
    initial begin
        int n;
        logic [15:0] a;
        logic [15:0] b;
        start8 = 1'b0;
        dvd8   = '0;
        dvs8   = '0;
        wait (rst8);
        for (int i = 0; i < 2000; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                #1;
                n++;
            end while (!(sb8.size() == 0 && !busy8 && !done8) && n < 100);
            if (n >= 100) begin
                n_cmp++;
                n_err++;
                $display("FAIL wait_idle8: still busy after %0d cycles", n);
            end
            a      = rnd(8, 0);
            b      = rnd(8, 1);
            dvd8   = a[7:0];
            dvs8   = b[7:0];
            start8 = 1'b1;
            sb8.push_back(mdl(a, b, 8, cyc));
            @(negedge clk);
            #1;
            start8 = 1'b0;
            dvd8   = 8'($urandom);
            dvs8   = 8'($urandom);
        end
        fin8 = 1;
    end

    // main sequence
    initial begin
        int c0;
        int n;
        reset_n  = 1'b0;
        rst8     = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_div_by_zero", div_by_zero, 0);
        #1;
        reset_n = 1'b1;
        rst8    = 1'b1;

        issue(16'd100, 16'd7);
        issue(16'hFFFF, 16'h0001);
        issue(16'd3, 16'd10);
        issue(16'h1234, 16'h0000);

        issue(16'd1000, 16'd3);
        repeat (3) begin
            @(negedge clk);
            #1;
        end
        dividend = 16'd5;
        divisor  = 16'd5;
        start    = 1'b1;
        @(negedge clk);
        #1;
        start    = 1'b0;
        dividend = 16'd77;
        divisor  = 16'd0;
        issue(16'd5, 16'd5);

        issue(16'd50000, 16'd9);
        repeat (7) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_quotient", quotient, 0);
        chk("arst_remainder", remainder, 0);
        chk("arst_div_by_zero", div_by_zero, 0);
        sb.delete();
        last_q = '0;
        last_r = '0;
        last_z = 1'b0;
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        issue(16'd50000, 16'd9);

        for (int i = 0; i < 2000; i++) begin
            issue(rnd(16, 0), rnd(16, 1));
        end
        wait_idle();

        n = 0;
        while (!fin8 && n < 50000) begin
            @(negedge clk);
            n++;
        end
        if (!fin8) begin
            n_cmp++;
            n_err++;
            $display("FAIL fin8: 8-bit stream did not finish");
        end
        repeat (20) @(negedge clk);
        c0 = sb8.size();
        chk("sb8_drained", c0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

endmodule
